// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//
// Multi-channel push-button conditioner. Each raw active-low pin is passed
// through a two-flop synchroniser and then debounced: a new level is accepted
// only after it has been seen for DEB_CYCLES consecutive clocks. The clean
// level is presented active-low on `button`. One-cycle pulses mark each
// debounced press (1->0), each debounced release (0->1), and a press that has
// been held for LONG_CYCLES clocks (one pulse per press, no auto-repeat).
//
// Parameters:
//   N_BTN       number of independent channels
//   DEB_CYCLES  stable clocks needed to accept a new level (>= 2)
//   LONG_CYCLES clocks a debounced press is held before long_press (> DEB_CYCLES)
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   button_raw    raw pins, active-low, asynchronous to clk
//   button        debounced level, active-low (all 1s out of reset)
//   press         one-cycle pulse in the first cycle button[i] reads 0
//   release_pulse one-cycle pulse in the first cycle button[i] reads 1
//                 (named this way because `release` is a reserved word)
//   long_press    one-cycle pulse when a press has been held LONG_CYCLES clocks
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int N_BTN       = 4,
  parameter int DEB_CYCLES  = 270_000,
  parameter int LONG_CYCLES = 27_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button_raw,
  output logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    logic          s1_q;
    logic          s2_q;
    logic          stable_q, stable_d;
    logic [DW-1:0] dcnt_q,   dcnt_d;
    logic [HW-1:0] hcnt_q,   hcnt_d;
    logic          press_q,  press_d;
    logic          rel_q,    rel_d;
    logic          long_q,   long_d;

    always_comb begin
      stable_d = stable_q;
      dcnt_d   = '0;
      // Any sample matching the accepted level leaves dcnt at zero, so only an
      // unbroken run of DEB_CYCLES differing samples can change the level.
      if (s2_q != stable_q) begin
        if (dcnt_q == DEB_LAST) begin
          stable_d = s2_q;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      // Pulses are registered alongside stable, so they line up with the
      // first cycle the new level is visible on button.
      press_d = stable_q & ~stable_d;
      rel_d   = ~stable_q & stable_d;

      // Hold counter saturates at LONG_CYCLES; the pulse is taken on the
      // step into saturation, which can only happen once per press.
      hcnt_d = '0;
      long_d = 1'b0;
      if (!stable_q) begin
        if (hcnt_q != LONG_MAX) begin
          hcnt_d = hcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q;
        end
        long_d = (hcnt_q == LONG_LAST);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1_q     <= 1'b1;
        s2_q     <= 1'b1;
        stable_q <= 1'b1;
        dcnt_q   <= '0;
        hcnt_q   <= '0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        s1_q     <= button_raw[gi];
        s2_q     <= s1_q;
        stable_q <= stable_d;
        dcnt_q   <= dcnt_d;
        hcnt_q   <= hcnt_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
        long_q   <= long_d;
      end
    end

    assign button[gi]        = stable_q;
    assign press[gi]         = press_q;
    assign release_pulse[gi] = rel_q;
    assign long_press[gi]    = long_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] button_raw = '0;
  logic [N-1:0] button, press, release_pulse, long_press;

  button_debounce #(
    .N_BTN(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LNG)
  ) dut (
    .clk(clk), .rst(rst), .button_raw(button_raw), .button(button),
    .press(press), .release_pulse(release_pulse), .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
    logic [3:0] b;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  done = 0;

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] b);
    ev_t e;
    e.c = c; e.p = p; e.r = r; e.l = l; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_neg(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic check_idle(input string name, input logic [3:0] b_exp);
    vectors++;
    if ({button, press, release_pulse, long_press} != {b_exp, 12'h000}) begin
      miscompares++;
      $display("FAIL %s: button=%b press=%b release=%b long=%b, want button=%b and no pulses",
               name, button, press, release_pulse, long_press, b_exp);
    end
  endtask

  // Monitor: every cycle with any pulse consumes one expected event.
  initial begin
    ev_t e;
    while (!done) begin
      @(negedge clk);
      #2;
      if (rst && (press != 0 || release_pulse != 0 || long_press != 0)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: cyc=%0d press=%b release=%b long=%b button=%b",
                   cyc, press, release_pulse, long_press, button);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.c || press != e.p || release_pulse != e.r ||
              long_press != e.l || button != e.b) begin
            miscompares++;
            $display("FAIL event: got cyc=%0d p=%b r=%b l=%b b=%b, want cyc=%0d p=%b r=%b l=%b b=%b",
                     cyc, press, release_pulse, long_press, button,
                     e.c, e.p, e.r, e.l, e.b);
          end else begin
            $display("event ok: cyc=%0d p=%b r=%b l=%b b=%b",
                     cyc, press, release_pulse, long_press, button);
          end
        end
      end
    end
  end

  initial begin
    int n;

    // 1. Reset held with all pins pressed: outputs stay idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check_idle("reset_hold", 4'b1111);
    end
    @(negedge clk);
    rst = 1'b1;
    n = cyc;
    push(n + 6,  4'b1111, 4'b0000, 4'b0000, 4'b0000);
    push(n + 26, 4'b0000, 4'b0000, 4'b1111, 4'b0000);
    wait_neg(30);
    button_raw = 4'b1111;
    push(cyc + 6, 4'b0000, 4'b1111, 4'b0000, 4'b1111);
    wait_neg(12);

    // 2. Bounce on channel 1: never accepted.
    button_raw[1] = 1'b0; wait_neg(3);
    button_raw[1] = 1'b1; wait_neg(1);
    button_raw[1] = 1'b0; wait_neg(3);
    button_raw[1] = 1'b1; wait_neg(12);
    #1 check_idle("bounce_reject", 4'b1111);

    // 3. Clean press/release on channel 2.
    button_raw[2] = 1'b0;
    push(cyc + 6, 4'b0100, 4'b0000, 4'b0000, 4'b1011);
    wait_neg(10);
    button_raw[2] = 1'b1;
    push(cyc + 6, 4'b0000, 4'b0100, 4'b0000, 4'b1111);
    wait_neg(12);

    // 4. Long press on channel 3: two long holds, then a short one.
    for (int k = 0; k < 2; k++) begin
      button_raw[3] = 1'b0;
      n = cyc;
      push(n + 6,  4'b1000, 4'b0000, 4'b0000, 4'b0111);
      push(n + 26, 4'b0000, 4'b0000, 4'b1000, 4'b0111);
      wait_neg(40);
      button_raw[3] = 1'b1;
      push(cyc + 6, 4'b0000, 4'b1000, 4'b0000, 4'b1111);
      wait_neg(12);
    end
    button_raw[3] = 1'b0;
    push(cyc + 6, 4'b1000, 4'b0000, 4'b0000, 4'b0111);
    wait_neg(15);
    button_raw[3] = 1'b1;
    push(cyc + 6, 4'b0000, 4'b1000, 4'b0000, 4'b1111);
    wait_neg(30);

    // 5. Two channels pressed in the same cycle.
    button_raw = 4'b0101;
    n = cyc;
    push(n + 6,  4'b1010, 4'b0000, 4'b0000, 4'b0101);
    push(n + 26, 4'b0000, 4'b0000, 4'b1010, 4'b0101);
    wait_neg(30);
    button_raw = 4'b1111;
    push(cyc + 6, 4'b0000, 4'b1010, 4'b0000, 4'b1111);
    wait_neg(12);

    // 6. Reset while channel 0 has held for 15 cycles.
    button_raw[0] = 1'b0;
    n = cyc;
    push(n + 6, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
    wait_neg(21);
    rst = 1'b0;
    #1 check_idle("reset_mid_hold", 4'b1111);
    wait_neg(3);
    rst = 1'b1;
    n = cyc;
    push(n + 6,  4'b0001, 4'b0000, 4'b0000, 4'b1110);
    push(n + 26, 4'b0000, 4'b0000, 4'b0001, 4'b1110);
    wait_neg(30);
    button_raw[0] = 1'b1;
    push(cyc + 6, 4'b0000, 4'b0001, 4'b0000, 4'b1111);
    wait_neg(12);

    // Every expected event must have been observed.
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events: %0d still pending, want 0 (next due cyc=%0d)",
               exp_q.size(), exp_q[0].c);
    end
    #1 check_idle("final_idle", 4'b1111);

    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
